keypad_event_fifo: RTL and testbench

- Scans the 3-column x 4-row door keypad and debounces it.
- Encodes each confirmed press as a 4-bit key code and queues it in a small FIFO.
- Sits upstream of the CPU's RA input and replaces raw keypad levels with discrete, acknowledged key events, so a held key is never read twice.
- Drives the keypad column lines and reads the row lines.

---
 rtl/keypad_event_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_keypad_event_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_fifo.sv
// Keypad scanner for a 3x4 matrix: column scan, frame debounce, and a small
// FIFO of key events popped with keyAck.
module keypad_event_fifo #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [2:0]                    columnSel,
  input  logic [3:0]                    scanData,
  output logic [3:0]                    keyCode,
  output logic                          keyValid,
  input  logic                          keyAck,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overflow
);

  localparam int unsigned TMR_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  logic [TMR_W-1:0]  tmr_q;
  logic [2:0]        col_q;
  logic [3:0]        slot0_q;
  logic [3:0]        slot1_q;
  logic              tick_c;
  logic              frame_ev_c;
  logic [11:0]       frame_c;
  logic [3:0]        ones_c;
  logic [3:0]        code_c;
  logic              none_c;
  logic              single_c;

  state_t            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic              push_c;
  logic [3:0]        push_code_c;

  logic [3:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [FCNT_W-1:0] count_q;
  logic              overflow_q;
  logic              pop_c;
  logic              full_c;
  logic              wr_c;

  // Row r / column c to key code; row 3 holds '*', '0', '#'.
  function automatic logic [3:0] code_map(input int unsigned r, input int unsigned c);
    if (r < 3) begin
      return 4'(3 * r + c + 1);
    end
    case (c)
      0:       return 4'hA;
      1:       return 4'h0;
      default: return 4'hB;
    endcase
  endfunction

  assign tick_c     = (tmr_q == TMR_W'(SCAN_DIV - 1));
  assign frame_ev_c = tick_c && col_q[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q   <= '0;
      col_q   <= 3'b001;
      slot0_q <= '0;
      slot1_q <= '0;
    end else if (tick_c) begin
      tmr_q <= '0;
      if (col_q[0]) slot0_q <= scanData;
      if (col_q[1]) slot1_q <= scanData;
      col_q <= {col_q[1:0], col_q[2]};
    end else begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  // Column 2 is classified live, in the cycle it is sampled.
  assign frame_c = {scanData, slot1_q, slot0_q};

  always_comb begin
    ones_c = '0;
    code_c = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        if (frame_c[c*4 + r]) begin
          ones_c = ones_c + 4'(1);
          code_c = code_map(r, c);
        end
      end
    end
  end

  assign none_c   = (ones_c == 4'd0);
  assign single_c = (ones_c == 4'd1);
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    push_c      = 1'b0;
    push_code_c = cand_q;
    if (frame_ev_c) begin
      case (state_q)
        S_IDLE: begin
          if (single_c) begin
            cand_d = code_c;
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              push_c      = 1'b1;
              push_code_c = code_c;
              state_d     = S_PRESSED;
            end else begin
              state_d = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (single_c && code_c == cand_q) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_W'(DEBOUNCE_CNT)) begin
              push_c  = 1'b1;
              state_d = S_PRESSED;
            end
          end else if (single_c) begin
            cand_d = code_c;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (none_c) begin
            cnt_d   = CNT_W'(1);
            state_d = (DEBOUNCE_CNT == 1) ? S_IDLE : S_RELEASE;
          end
        end
        default: begin
          if (!none_c) begin
            state_d = S_PRESSED;
          end else begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c >= CNT_W'(DEBOUNCE_CNT)) state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push.
  assign pop_c  = keyAck && (count_q != '0);
  assign full_c = (count_q == FCNT_W'(FIFO_DEPTH));
  assign wr_c   = push_c && (!full_c || pop_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_c) begin
        mem_q[wr_ptr_q] <= push_code_c;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_c, pop_c})
        2'b10:   count_q <= count_q + FCNT_W'(1);
        2'b01:   count_q <= count_q - FCNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_c && full_c && !pop_c) overflow_q <= 1'b1;
    end
  end

  assign columnSel = col_q;
  assign keyValid  = (count_q != '0);
  assign keyCode   = keyValid ? mem_q[rd_ptr_q] : 4'h0;
  assign fifoCount = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Bench for keypad_event_fifo: keypad matrix model driven per column, and a
// queue of expected key codes checked as entries are popped.
module tb_keypad_event_fifo;

  localparam int unsigned SD = 4;
  localparam int unsigned DC = 3;
  localparam int unsigned FD = 4;
  localparam int unsigned FRAME = 3 * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] columnSel;
  logic [3:0] scanData;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyAck;
  logic [2:0] fifoCount;
  logic       overflow;

  logic [2:0][3:0] kp;
  logic [3:0]      exp_q [$];
  int              n_checks = 0;
  int              n_fail   = 0;

  keypad_event_fifo #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .columnSel (columnSel),
    .scanData  (scanData),
    .keyCode   (keyCode),
    .keyValid  (keyValid),
    .keyAck    (keyAck),
    .fifoCount (fifoCount),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  assign scanData = (columnSel[0] ? kp[0] : 4'h0) |
                    (columnSel[1] ? kp[1] : 4'h0) |
                    (columnSel[2] ? kp[2] : 4'h0);

  // Reset released on a falling edge so frames end on every 12th rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    kp = '0;
    keyAck = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic press_release(input int r, input int c, input int pf, input int rf);
    kp = '0;
    kp[c][r] = 1'b1;
    wait_frames(pf);
    kp = '0;
    wait_frames(rf);
  endtask

  task automatic pop_check(input string name);
    logic [3:0] e;
    n_checks++;
    if (keyValid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s keyValid: got %b want 1", name, keyValid);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard empty: keyCode got %h want none", name, keyCode);
    end else begin
      e = exp_q.pop_front();
      if (keyCode !== e) begin
        n_fail++;
        $display("FAIL %s keyCode: got %h want %h", name, keyCode, e);
      end
    end
    keyAck = 1'b1;
    @(negedge clk);
    keyAck = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] e;
    do_reset();
    n_checks++;
    if ({columnSel, keyCode, keyValid, fifoCount, overflow} !== {3'b001, 4'h0, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got col=%b code=%h v=%b cnt=%0d ovf=%b want col=001 code=0 v=0 cnt=0 ovf=0",
               columnSel, keyCode, keyValid, fifoCount, overflow);
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      e = 3'b001 << ((k / SD) % 3);
      n_checks++;
      if (columnSel !== e || keyValid !== 1'b0 || keyCode !== 4'h0 || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL free_run cycle %0d: got col=%b v=%b code=%h ovf=%b want col=%b v=0 code=0 ovf=0",
                 k, columnSel, keyValid, keyCode, overflow, e);
      end
    end
  endtask

  task automatic test_hold_5();
    do_reset();
    kp[1][1] = 1'b1;
    repeat (3 * FRAME - 1) @(negedge clk);
    n_checks++;
    if (keyValid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold5_early: keyValid got %b want 0", keyValid);
    end
    @(negedge clk);
    exp_q.push_back(4'h5);
    n_checks++;
    if (keyValid !== 1'b1 || keyCode !== 4'h5 || fifoCount !== 3'd1) begin
      n_fail++;
      $display("FAIL hold5_push: got v=%b code=%h cnt=%0d want v=1 code=5 cnt=1",
               keyValid, keyCode, fifoCount);
    end
    wait_frames(3);
    kp = '0;
    wait_frames(4);
    n_checks++;
    if (fifoCount !== 3'd1) begin
      n_fail++;
      $display("FAIL hold5_no_repeat: fifoCount got %0d want 1", fifoCount);
    end
    pop_check("hold5_pop");
    n_checks++;
    if (keyValid !== 1'b0 || keyCode !== 4'h0) begin
      n_fail++;
      $display("FAIL hold5_empty: got v=%b code=%h want v=0 code=0", keyValid, keyCode);
    end
  endtask

  task automatic test_reject();
    do_reset();
    press_release(1, 1, 2, 1);
    n_checks++;
    if (fifoCount !== 3'd0) begin
      n_fail++;
      $display("FAIL reject_short: fifoCount got %0d want 0", fifoCount);
    end
    press_release(3, 2, 3, 3);
    exp_q.push_back(4'hB);
    n_checks++;
    if (fifoCount !== 3'd1) begin
      n_fail++;
      $display("FAIL reject_hash_count: fifoCount got %0d want 1", fifoCount);
    end
    pop_check("reject_hash");
  endtask

  task automatic test_push_pop_empty();
    do_reset();
    kp[2][2] = 1'b1;
    repeat (3 * FRAME - 1) @(negedge clk);
    keyAck = 1'b1;
    @(negedge clk);
    keyAck = 1'b0;
    exp_q.push_back(4'h9);
    n_checks++;
    if (fifoCount !== 3'd1 || keyCode !== 4'h9) begin
      n_fail++;
      $display("FAIL empty_push_pop: got cnt=%0d code=%h want cnt=1 code=9", fifoCount, keyCode);
    end
    kp = '0;
    pop_check("empty_push_pop_pop");
  endtask

  task automatic test_overflow();
    do_reset();
    press_release(0, 0, 3, 3); exp_q.push_back(4'h1);
    press_release(0, 1, 3, 3); exp_q.push_back(4'h2);
    press_release(0, 2, 3, 3); exp_q.push_back(4'h3);
    n_checks++;
    if (overflow !== 1'b0 || fifoCount !== 3'd3) begin
      n_fail++;
      $display("FAIL ovf_pre: got ovf=%b cnt=%0d want ovf=0 cnt=3", overflow, fifoCount);
    end
    press_release(3, 0, 3, 3); exp_q.push_back(4'hA);
    press_release(3, 1, 3, 3);
    n_checks++;
    if (fifoCount !== 3'd4 || overflow !== 1'b1 || keyCode !== 4'h1) begin
      n_fail++;
      $display("FAIL ovf_full: got cnt=%0d ovf=%b head=%h want cnt=4 ovf=1 head=1",
               fifoCount, overflow, keyCode);
    end
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovf_pop%0d", i));
    n_checks++;
    if (keyValid !== 1'b0 || keyCode !== 4'h0 || fifoCount !== 3'd0) begin
      n_fail++;
      $display("FAIL ovf_drained: got v=%b code=%h cnt=%0d want v=0 code=0 cnt=0",
               keyValid, keyCode, fifoCount);
    end
    keyAck = 1'b1;
    @(negedge clk);
    keyAck = 1'b0;
    n_checks++;
    if (fifoCount !== 3'd0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_empty: got cnt=%0d ovf=%b want cnt=0 ovf=1", fifoCount, overflow);
    end
  endtask

  task automatic test_multi();
    do_reset();
    kp[0][0] = 1'b1;
    kp[1][0] = 1'b1;
    wait_frames(5);
    n_checks++;
    if (fifoCount !== 3'd0) begin
      n_fail++;
      $display("FAIL multi_hold: fifoCount got %0d want 0", fifoCount);
    end
    kp[1][0] = 1'b0;
    wait_frames(2);
    n_checks++;
    if (fifoCount !== 3'd0) begin
      n_fail++;
      $display("FAIL multi_single_early: fifoCount got %0d want 0", fifoCount);
    end
    wait_frames(1);
    exp_q.push_back(4'h1);
    n_checks++;
    if (fifoCount !== 3'd1) begin
      n_fail++;
      $display("FAIL multi_single_push: fifoCount got %0d want 1", fifoCount);
    end
    kp = '0;
    pop_check("multi_pop");
  endtask

  task automatic test_full_push_pop();
    logic [3:0] e;
    do_reset();
    press_release(0, 0, 3, 3); exp_q.push_back(4'h1);
    press_release(0, 1, 3, 3); exp_q.push_back(4'h2);
    press_release(0, 2, 3, 3); exp_q.push_back(4'h3);
    press_release(3, 0, 3, 3); exp_q.push_back(4'hA);
    kp[1][3] = 1'b1;
    repeat (3 * FRAME - 1) @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (fifoCount !== 3'd4 || keyCode !== e) begin
      n_fail++;
      $display("FAIL full_pre: got cnt=%0d head=%h want cnt=4 head=%h", fifoCount, keyCode, e);
    end
    keyAck = 1'b1;
    @(negedge clk);
    keyAck = 1'b0;
    exp_q.push_back(4'h0);
    n_checks++;
    if (fifoCount !== 3'd4 || overflow !== 1'b0 || keyCode !== exp_q[0]) begin
      n_fail++;
      $display("FAIL full_push_pop: got cnt=%0d ovf=%b head=%h want cnt=4 ovf=0 head=%h",
               fifoCount, overflow, keyCode, exp_q[0]);
    end
    kp = '0;
    for (int i = 0; i < 4; i++) pop_check($sformatf("full_drain%0d", i));
    repeat (3 * FRAME - 4) @(negedge clk);
    press_release(2, 0, 3, 3);
    exp_q.push_back(4'h7);
    kp[1][1] = 1'b1;
    wait_frames(1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (keyValid !== 1'b1 || keyCode !== 4'h7) begin
      n_fail++;
      $display("FAIL pre_reset_state: got v=%b code=%h want v=1 code=7", keyValid, keyCode);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({columnSel, keyCode, keyValid, fifoCount, overflow} !== {3'b001, 4'h0, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got col=%b code=%h v=%b cnt=%0d ovf=%b want col=001 code=0 v=0 cnt=0 ovf=0",
               columnSel, keyCode, keyValid, fifoCount, overflow);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    wait_frames(2);
    kp = '0;
    wait_frames(2);
    n_checks++;
    if (fifoCount !== 3'd0 || keyValid !== 1'b0) begin
      n_fail++;
      $display("FAIL debounce_discarded: got cnt=%0d v=%b want cnt=0 v=0", fifoCount, keyValid);
    end
  endtask

  initial begin
    rst = 1'b0;
    kp = '0;
    keyAck = 1'b0;
    test_reset();
    test_hold_5();
    test_reject();
    test_push_pop_empty();
    test_overflow();
    test_multi();
    test_full_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "timeout");
  end

endmodule
